// File: rtl/sap_controller.sv
// SAP controller-sequencer: one-hot T-state ring plus combinational decode of
// (T-state, opcode) into the datapath register enables and bus-driver strobes.
//
//   state | meaning
//   T1    | fetch: PC drives bus, MAR loads
//   T2    | fetch: PC increments
//   T3    | fetch: RAM drives bus, IR loads
//   T4    | execute phase 1 (HLT latches the halt flag here and parks)
//   T5    | execute phase 2
//   T6    | execute phase 3, then wrap to T1
module sap_controller #(
    parameter int OPCODE_WIDTH = 4,
    parameter int NUM_TSTATES  = 6
) (
    input  logic                    clk,
    input  logic                    clr_n,
    input  logic                    i_run,
    input  logic [OPCODE_WIDTH-1:0] i_opcode,
    output logic [NUM_TSTATES-1:0]  o_tstate,
    output logic                    o_halted,
    output logic                    o_pc_inc,
    output logic                    o_pc_out,
    output logic                    o_pc_load,
    output logic                    o_mar_load,
    output logic                    o_ram_out,
    output logic                    o_ir_load,
    output logic                    o_ir_out,
    output logic                    o_a_load,
    output logic                    o_a_out,
    output logic                    o_b_load,
    output logic                    o_alu_sub,
    output logic                    o_alu_out,
    output logic                    o_out_load
);

    typedef enum logic [NUM_TSTATES-1:0] {
        T1 = NUM_TSTATES'(6'b000001),
        T2 = NUM_TSTATES'(6'b000010),
        T3 = NUM_TSTATES'(6'b000100),
        T4 = NUM_TSTATES'(6'b001000),
        T5 = NUM_TSTATES'(6'b010000),
        T6 = NUM_TSTATES'(6'b100000)
    } tstate_t;

    localparam logic [OPCODE_WIDTH-1:0] OP_LDA = OPCODE_WIDTH'(4'b0000);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(4'b0001);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(4'b0010);
    localparam logic [OPCODE_WIDTH-1:0] OP_JMP = OPCODE_WIDTH'(4'b0011);
    localparam logic [OPCODE_WIDTH-1:0] OP_OUT = OPCODE_WIDTH'(4'b1110);
    localparam logic [OPCODE_WIDTH-1:0] OP_HLT = OPCODE_WIDTH'(4'b1111);

    tstate_t r_tstate;
    tstate_t w_tstate_next;
    logic    r_halted;
    logic    w_halted_next;
    logic    w_advance;
    logic    w_active;

    assign w_advance = i_run & ~r_halted;
    // clr_n gates the strobes too, so the T1 decode cannot leak out during reset
    assign w_active  = clr_n & w_advance;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_tstate <= T1;
            r_halted <= 1'b0;
        end else begin
            r_tstate <= w_tstate_next;
            r_halted <= w_halted_next;
        end
    end

    always_comb begin
        w_tstate_next = r_tstate;
        w_halted_next = r_halted;
        o_pc_inc      = 1'b0;
        o_pc_out      = 1'b0;
        o_pc_load     = 1'b0;
        o_mar_load    = 1'b0;
        o_ram_out     = 1'b0;
        o_ir_load     = 1'b0;
        o_ir_out      = 1'b0;
        o_a_load      = 1'b0;
        o_a_out       = 1'b0;
        o_b_load      = 1'b0;
        o_alu_sub     = 1'b0;
        o_alu_out     = 1'b0;
        o_out_load    = 1'b0;

        if (w_advance) begin
            case (r_tstate)
                T1:      w_tstate_next = T2;
                T2:      w_tstate_next = T3;
                T3:      w_tstate_next = T4;
                T4: begin
                    if (i_opcode == OP_HLT) w_halted_next = 1'b1;
                    else                    w_tstate_next = T5;
                end
                T5:      w_tstate_next = T6;
                T6:      w_tstate_next = T1;
                default: w_tstate_next = T1;
            endcase
        end

        if (w_active) begin
            case (r_tstate)
                T1: begin
                    o_pc_out   = 1'b1;
                    o_mar_load = 1'b1;
                end
                T2: o_pc_inc = 1'b1;
                T3: begin
                    o_ram_out = 1'b1;
                    o_ir_load = 1'b1;
                end
                T4: begin
                    case (i_opcode)
                        OP_LDA, OP_ADD, OP_SUB: begin
                            o_ir_out   = 1'b1;
                            o_mar_load = 1'b1;
                        end
                        OP_JMP: begin
                            o_ir_out  = 1'b1;
                            o_pc_load = 1'b1;
                        end
                        OP_OUT: begin
                            o_a_out    = 1'b1;
                            o_out_load = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T5: begin
                    case (i_opcode)
                        OP_LDA: begin
                            o_ram_out = 1'b1;
                            o_a_load  = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            o_ram_out = 1'b1;
                            o_b_load  = 1'b1;
                            o_alu_sub = (i_opcode == OP_SUB);
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    if (i_opcode == OP_ADD || i_opcode == OP_SUB) begin
                        o_alu_out = 1'b1;
                        o_a_load  = 1'b1;
                        o_alu_sub = (i_opcode == OP_SUB);
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_tstate = r_tstate;
    assign o_halted = r_halted;

endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: directed instruction sequences followed by random
// opcode/run traffic, all compared against a T-index/halt-flag reference model.
module tb_sap_controller;

    logic       clk;
    logic       clr_n;
    logic       i_run;
    logic [3:0] i_opcode;
    logic [5:0] o_tstate;
    logic       o_halted;
    logic       o_pc_inc, o_pc_out, o_pc_load, o_mar_load, o_ram_out, o_ir_load;
    logic       o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_sub, o_alu_out, o_out_load;

    int checks = 0;
    int errors = 0;

    int tm = 1;        // model T-state number, 1..6
    bit hm = 1'b0;     // model halt flag

    localparam int PC_INC = 12, PC_OUT = 11, PC_LOAD = 10, MAR_LOAD = 9, RAM_OUT = 8;
    localparam int IR_LOAD = 7, IR_OUT = 6, A_LOAD = 5, A_OUT = 4, B_LOAD = 3;
    localparam int ALU_SUB = 2, ALU_OUT = 1, OUT_LOAD = 0;

    logic [12:0] w_obs;
    assign w_obs = {o_pc_inc, o_pc_out, o_pc_load, o_mar_load, o_ram_out, o_ir_load,
                    o_ir_out, o_a_load, o_a_out, o_b_load, o_alu_sub, o_alu_out, o_out_load};

    sap_controller dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .i_run      (i_run),
        .i_opcode   (i_opcode),
        .o_tstate   (o_tstate),
        .o_halted   (o_halted),
        .o_pc_inc   (o_pc_inc),
        .o_pc_out   (o_pc_out),
        .o_pc_load  (o_pc_load),
        .o_mar_load (o_mar_load),
        .o_ram_out  (o_ram_out),
        .o_ir_load  (o_ir_load),
        .o_ir_out   (o_ir_out),
        .o_a_load   (o_a_load),
        .o_a_out    (o_a_out),
        .o_b_load   (o_b_load),
        .o_alu_sub  (o_alu_sub),
        .o_alu_out  (o_alu_out),
        .o_out_load (o_out_load)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction table: which strobes each phase of each instruction raises.
    function automatic logic [12:0] exp_strobes(int t, logic [3:0] op, bit active);
        logic [12:0] m;
        m = '0;
        if (active) begin
            if (t == 1) begin m[PC_OUT] = 1; m[MAR_LOAD] = 1; end
            if (t == 2) m[PC_INC] = 1;
            if (t == 3) begin m[RAM_OUT] = 1; m[IR_LOAD] = 1; end
            case (op)
                4'h0: begin
                    if (t == 4) begin m[IR_OUT] = 1; m[MAR_LOAD] = 1; end
                    if (t == 5) begin m[RAM_OUT] = 1; m[A_LOAD] = 1; end
                end
                4'h1, 4'h2: begin
                    if (t == 4) begin m[IR_OUT] = 1; m[MAR_LOAD] = 1; end
                    if (t == 5) begin m[RAM_OUT] = 1; m[B_LOAD] = 1; end
                    if (t == 6) begin m[ALU_OUT] = 1; m[A_LOAD] = 1; end
                    if (op == 4'h2 && t >= 5) m[ALU_SUB] = 1;
                end
                4'h3: if (t == 4) begin m[IR_OUT] = 1; m[PC_LOAD] = 1; end
                4'hE: if (t == 4) begin m[A_OUT] = 1; m[OUT_LOAD] = 1; end
                default: ;
            endcase
        end
        return m;
    endfunction

    task automatic check_all(input string tag);
        logic [5:0]  exp_t;
        logic [12:0] exp_s;
        bit          active;
        active = clr_n && i_run && !hm;
        exp_t  = 6'(1 << (tm - 1));
        exp_s  = exp_strobes(tm, i_opcode, active);
        checks++;
        assert (o_tstate === exp_t) else begin
            errors++;
            $error("FAIL %s.tstate observed=%b expected=%b", tag, o_tstate, exp_t);
        end
        checks++;
        assert (o_halted === hm) else begin
            errors++;
            $error("FAIL %s.halted observed=%b expected=%b", tag, o_halted, hm);
        end
        checks++;
        assert (w_obs === exp_s) else begin
            errors++;
            $error("FAIL %s.strobes observed=%b expected=%b (t=%0d op=%h)", tag, w_obs, exp_s, tm, i_opcode);
        end
        checks++;
        assert ($onehot(o_tstate)) else begin
            errors++;
            $error("FAIL %s.onehot observed=%b expected=one-hot", tag, o_tstate);
        end
        checks++;
        assert ($countones({o_pc_out, o_ram_out, o_ir_out, o_a_out, o_alu_out}) <= 1) else begin
            errors++;
            $error("FAIL %s.bus observed=%b expected=at most one driver", tag,
                   {o_pc_out, o_ram_out, o_ir_out, o_a_out, o_alu_out});
        end
    endtask

    task automatic model_edge();
        if (clr_n && i_run && !hm) begin
            if (tm == 4 && i_opcode == 4'hF) hm = 1'b1;
            else                             tm = (tm == 6) ? 1 : tm + 1;
        end
    endtask

    task automatic step(input bit run, input logic [3:0] op, input string tag);
        @(negedge clk);
        i_run    = run;
        i_opcode = op;
        #1;
        check_all(tag);
        @(posedge clk);
        model_edge();
    endtask

    // Asserts clr_n between edges and checks the state before the next edge.
    task automatic reset_pulse(input string tag);
        @(negedge clk);
        #1 clr_n = 1'b0;
        #1;
        tm = 1;
        hm = 1'b0;
        check_all(tag);
        #1 clr_n = 1'b1;
        @(posedge clk);
        model_edge();
    endtask

    task automatic run_to(input int target, input logic [3:0] op, input string tag);
        for (int k = 0; k < 12 && tm != target; k++) step(1'b1, op, tag);
    endtask

    task automatic run_instr(input logic [3:0] op, input string tag);
        for (int k = 0; k < 6; k++) step(1'b1, op, tag);
    endtask

    initial begin
        clr_n    = 1'b0;
        i_run    = 1'b1;
        i_opcode = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1 check_all("por");
        clr_n = 1'b1;
        @(posedge clk);
        model_edge();

        run_instr(4'h0, "lda");
        step(1'b1, 4'h0, "wrap_t1");
        run_to(1, 4'h0, "align");
        run_instr(4'h1, "add");
        run_instr(4'h2, "sub");
        run_instr(4'h3, "jmp");
        run_instr(4'hE, "out");
        run_instr(4'h5, "nop");

        run_to(5, 4'h1, "add_to_t5");
        @(negedge clk);
        i_run = 1'b1;
        #1 check_all("add_t5");
        #1 clr_n = 1'b0;
        #1;
        tm = 1;
        hm = 1'b0;
        check_all("rst_mid");
        #1 clr_n = 1'b1;
        @(posedge clk);
        model_edge();

        run_to(2, 4'h0, "to_t2");
        repeat (5) step(1'b0, 4'h0, "pause");
        step(1'b1, 4'h0, "resume");
        step(1'b1, 4'h0, "after_resume");

        run_to(1, 4'hF, "align_hlt");
        run_to(4, 4'hF, "hlt_fetch");
        step(1'b1, 4'hF, "hlt_t4");
        for (int k = 0; k < 20; k++)
            step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), "halted");
        reset_pulse("hlt_clear");
        step(1'b1, 4'h0, "post_hlt");

        for (int k = 0; k < 10000; k++) begin
            if ($urandom_range(0, 63) == 0) reset_pulse("rand_rst");
            else step($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
